branch_redirect_sequencer: RTL and testbench

Sequences PC redirection and pipeline squashing around branch resolution. It selects the next fetch PC from three sources, in priority order: EX-stage mispredict correction, ID-stage predicted-taken target, and sequential PC. It drives the IF/ID and ID/EX flush controls for the required squash window and holds a correction pending across stalls. It sits between the branch control cluster (mispredict/prediction outputs) and the PC register / pipeline registers of the front end.

---
 rtl/branch_redirect_sequencer_pkg.sv | 28 ++
 rtl/branch_redirect_sequencer_if.sv | 27 ++
 rtl/branch_redirect_sequencer_redirect_mux.sv | 28 ++
 rtl/branch_redirect_sequencer.sv | 154 +++++++++++++++
 tb/tb_branch_redirect_sequencer.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/branch_redirect_sequencer_pkg.sv
// Shared types and constants for the branch redirect sequencer:
// FSM state encoding, one-hot next-PC source select and counter limits.
package branch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PEND,
        SQUASH
    } redir_state_t;

    localparam int          FlushDepthDefault = 2;
    localparam int          SqCntW            = $clog2(FlushDepthDefault) + 1;
    localparam logic [15:0] MispredCntMax     = 16'hFFFF;

    typedef struct packed {
        logic reset_pc;
        logic corr;
        logic pend;
        logic pred;
        logic seq;
    } redir_sel_t;

    // Squash counter width for an arbitrary flush depth.
    function automatic int sq_cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/branch_redirect_sequencer_if.sv
// Bundle between the branch control cluster / front end and the redirect sequencer.
interface branch_redirect_if #(
    parameter int WordSize = 32
);
    logic                mispred;
    logic [WordSize-1:0] corr_pc;
    logic                pred_taken;
    logic [WordSize-1:0] pred_addr;
    logic [WordSize-1:0] seq_pc;
    logic                stall;
    logic [WordSize-1:0] npc;
    logic                pc_en;
    logic                flush_if_id;
    logic                flush_id_ex;
    logic                busy;
    logic [15:0]         mispred_cnt;

    modport master (
        output mispred, corr_pc, pred_taken, pred_addr, seq_pc, stall,
        input  npc, pc_en, flush_if_id, flush_id_ex, busy, mispred_cnt
    );

    modport slave (
        input  mispred, corr_pc, pred_taken, pred_addr, seq_pc, stall,
        output npc, pc_en, flush_if_id, flush_id_ex, busy, mispred_cnt
    );
endinterface

// File: rtl/branch_redirect_sequencer_redirect_mux.sv
// Next-PC AND-OR select driven by a one-hot source vector; the PC write
// enable is granted whenever a source is selected and the front end is not held.
module redirect_mux
    import branch_pkg::*;
#(
    parameter int WordSize = 32
) (
    input  redir_sel_t          sel,
    input  logic                hold,
    input  logic [WordSize-1:0] reset_pc,
    input  logic [WordSize-1:0] corr_pc,
    input  logic [WordSize-1:0] pend_pc,
    input  logic [WordSize-1:0] pred_addr,
    input  logic [WordSize-1:0] seq_pc,
    output logic [WordSize-1:0] npc,
    output logic                pc_en
);

    always_comb begin
        npc   = ({WordSize{sel.reset_pc}} & reset_pc)
              | ({WordSize{sel.corr}}     & corr_pc)
              | ({WordSize{sel.pend}}     & pend_pc)
              | ({WordSize{sel.pred}}     & pred_addr)
              | ({WordSize{sel.seq}}      & seq_pc);
        pc_en = (|sel) & ~hold;
    end

endmodule

// File: rtl/branch_redirect_sequencer.sv
// Chooses the next fetch PC (mispredict > predicted-taken > sequential), drives
// the IF/ID and ID/EX squash window and holds a correction across stalls.
module branch_redirect_sequencer
    import branch_pkg::*;
#(
    parameter int                  WordSize   = 32,
    parameter int                  FlushDepth = 2,
    parameter logic [WordSize-1:0] ResetPC    = '0
) (
    input  logic              clk,
    input  logic              rst,
    branch_redirect_if.slave  bus
);

    localparam int             CntW   = sq_cnt_width(FlushDepth);
    localparam logic [CntW-1:0] SqLoad = CntW'((FlushDepth > 1) ? (FlushDepth - 2) : 0);

    redir_state_t        state, state_nxt;
    logic [CntW-1:0]     sq_cnt, sq_cnt_nxt;
    logic [WordSize-1:0] pend_pc, pend_pc_nxt;
    logic [15:0]         mispred_cnt;

    redir_sel_t          sel;
    logic                hold;
    logic                flush_if_id;
    logic                flush_id_ex;
    logic                busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            sq_cnt  <= '0;
            pend_pc <= '0;
        end else begin
            state   <= state_nxt;
            sq_cnt  <= sq_cnt_nxt;
            pend_pc <= pend_pc_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        sq_cnt_nxt  = sq_cnt;
        pend_pc_nxt = pend_pc;
        case (state)
            IDLE: begin
                if (bus.mispred) begin
                    if (bus.stall) begin
                        state_nxt   = PEND;
                        pend_pc_nxt = bus.corr_pc;
                    end else if (FlushDepth > 1) begin
                        state_nxt  = SQUASH;
                        sq_cnt_nxt = SqLoad;
                    end
                end
            end
            PEND: begin
                if (!bus.stall) begin
                    if (FlushDepth > 1) begin
                        state_nxt  = SQUASH;
                        sq_cnt_nxt = SqLoad;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            SQUASH: begin
                if (!bus.stall) begin
                    if (sq_cnt == '0) begin
                        state_nxt = IDLE;
                    end else begin
                        sq_cnt_nxt = sq_cnt - 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Reset overrides every state so the front end restarts cleanly from ResetPC.
    always_comb begin
        sel         = '0;
        hold        = 1'b0;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
        busy        = (state != IDLE);
        if (rst) begin
            sel.reset_pc = 1'b1;
            flush_if_id  = 1'b1;
            flush_id_ex  = 1'b1;
            busy         = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    hold = bus.stall;
                    if (bus.mispred) begin
                        sel.corr    = 1'b1;
                        flush_if_id = !bus.stall;
                        flush_id_ex = !bus.stall;
                    end else if (bus.pred_taken) begin
                        sel.pred    = 1'b1;
                        flush_if_id = !bus.stall;
                    end else begin
                        sel.seq = 1'b1;
                    end
                end
                PEND: begin
                    sel.pend    = 1'b1;
                    hold        = bus.stall;
                    flush_if_id = !bus.stall;
                    flush_id_ex = !bus.stall;
                end
                SQUASH: begin
                    sel.seq     = 1'b1;
                    hold        = bus.stall;
                    flush_if_id = 1'b1;
                end
                default: begin
                    sel.seq = 1'b1;
                    hold    = bus.stall;
                end
            endcase
        end
    end

    // Stalled acceptances count too, since the correction is committed to PEND.
    always_ff @(posedge clk) begin
        if (rst) begin
            mispred_cnt <= '0;
        end else if (state == IDLE && bus.mispred && mispred_cnt != MispredCntMax) begin
            mispred_cnt <= mispred_cnt + 16'd1;
        end
    end

    redirect_mux #(
        .WordSize (WordSize)
    ) u_redirect_mux (
        .sel       (sel),
        .hold      (hold),
        .reset_pc  (ResetPC),
        .corr_pc   (bus.corr_pc),
        .pend_pc   (pend_pc),
        .pred_addr (bus.pred_addr),
        .seq_pc    (bus.seq_pc),
        .npc       (bus.npc),
        .pc_en     (bus.pc_en)
    );

    assign bus.flush_if_id = flush_if_id;
    assign bus.flush_id_ex = flush_id_ex;
    assign bus.busy        = busy;
    assign bus.mispred_cnt = mispred_cnt;

endmodule

// File: tb/tb_branch_redirect_sequencer.sv
// Self-checking bench: behavioural model of the redirect rules compared every
// cycle, directed scenarios, and a FlushDepth=1 instance for counter saturation.
module tb_branch_redirect_sequencer;

    localparam int FD = 2;

    logic clk;
    logic rst;
    logic rst2;

    int checks;
    int errors;

    branch_redirect_if #(.WordSize(32)) bus ();
    branch_redirect_if #(.WordSize(32)) bus2 ();

    branch_redirect_sequencer #(
        .WordSize   (32),
        .FlushDepth (FD),
        .ResetPC    (32'h0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    branch_redirect_sequencer #(
        .WordSize   (32),
        .FlushDepth (1),
        .ResetPC    (32'h0)
    ) dut_sat (
        .clk (clk),
        .rst (rst2),
        .bus (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs currently applied to the main DUT
    logic        cur_rst, cur_m, cur_pt, cur_st;
    logic [31:0] cur_cp, cur_pa, cur_sp;

    // Behavioural model: pending correction, remaining squash cycles, count
    bit          m_pending;
    logic [31:0] m_pend_val;
    int          m_squash_left;
    int          m_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        if (cur_rst) begin
            m_pending     = 0;
            m_pend_val    = '0;
            m_squash_left = 0;
            m_cnt         = 0;
        end else if (m_pending) begin
            if (!cur_st) begin
                m_pending     = 0;
                m_squash_left = FD - 1;
            end
        end else if (m_squash_left > 0) begin
            if (!cur_st) m_squash_left--;
        end else if (cur_m) begin
            if (m_cnt < 65535) m_cnt++;
            if (cur_st) begin
                m_pending  = 1;
                m_pend_val = cur_cp;
            end else begin
                m_squash_left = FD - 1;
            end
        end
    endtask

    task automatic compare_outputs();
        logic [31:0] e_npc;
        logic        e_en, e_fi, e_fe, e_busy;
        bit          skip_npc;
        skip_npc = 0;
        if (cur_rst) begin
            e_npc = 32'h0; e_en = 1; e_fi = 1; e_fe = 1; e_busy = 0;
        end else if (m_pending) begin
            e_npc = m_pend_val; e_en = !cur_st; e_fi = !cur_st; e_fe = !cur_st; e_busy = 1;
        end else if (m_squash_left > 0) begin
            e_npc = cur_sp; e_en = !cur_st; e_fi = 1; e_fe = 0; e_busy = 1;
        end else begin
            e_busy = 0;
            if (cur_m) begin
                e_npc = cur_cp; e_en = !cur_st; e_fi = !cur_st; e_fe = !cur_st;
                skip_npc = cur_st;
            end else if (cur_pt) begin
                e_npc = cur_pa; e_en = !cur_st; e_fi = !cur_st; e_fe = 0;
            end else begin
                e_npc = cur_sp; e_en = !cur_st; e_fi = 0; e_fe = 0;
            end
        end
        if (!skip_npc) check("npc", bus.npc, e_npc);
        check("pc_en", 32'(bus.pc_en), 32'(e_en));
        check("flush_if_id", 32'(bus.flush_if_id), 32'(e_fi));
        check("flush_id_ex", 32'(bus.flush_id_ex), 32'(e_fe));
        check("busy", 32'(bus.busy), 32'(e_busy));
        check("mispred_cnt", 32'(bus.mispred_cnt), 32'(m_cnt));
    endtask

    task automatic applyStimulus(input logic r, input logic m, input logic [31:0] cp,
                                 input logic pt, input logic [31:0] pa,
                                 input logic [31:0] sp, input logic st);
        @(posedge clk);
        model_step();
        #1;
        cur_rst = r; cur_m = m; cur_cp = cp; cur_pt = pt; cur_pa = pa; cur_sp = sp; cur_st = st;
        rst            = r;
        bus.mispred    = m;
        bus.corr_pc    = cp;
        bus.pred_taken = pt;
        bus.pred_addr  = pa;
        bus.seq_pc     = sp;
        bus.stall      = st;
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic main_flow();
        // Reset for two cycles, then release with sequential fetch
        applyStimulus(1, 0, 32'h0, 0, 32'h0, 32'h0, 0);
        applyStimulus(1, 0, 32'h0, 0, 32'h0, 32'h0, 0);
        check("rst_npc", bus.npc, 32'h0);
        check("rst_pc_en", 32'(bus.pc_en), 32'd1);
        check("rst_flush_if_id", 32'(bus.flush_if_id), 32'd1);
        check("rst_flush_id_ex", 32'(bus.flush_id_ex), 32'd1);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_cnt", 32'(bus.mispred_cnt), 32'd0);
        applyStimulus(0, 0, 32'h0, 0, 32'h0, 32'h4, 0);
        check("post_rst_npc", bus.npc, 32'h4);
        check("post_rst_flush", 32'(bus.flush_if_id), 32'd0);

        // Mispredict without stall
        applyStimulus(0, 1, 32'h100, 0, 32'h0, 32'h8, 0);
        check("mp_npc", bus.npc, 32'h100);
        check("mp_flush_id_ex", 32'(bus.flush_id_ex), 32'd1);
        applyStimulus(0, 0, 32'h0, 1, 32'h200, 32'h104, 0);
        check("sq_busy", 32'(bus.busy), 32'd1);
        check("sq_flush_if_id", 32'(bus.flush_if_id), 32'd1);
        check("sq_flush_id_ex", 32'(bus.flush_id_ex), 32'd0);
        check("sq_npc", bus.npc, 32'h104);
        applyStimulus(0, 0, 32'h0, 0, 32'h0, 32'h108, 0);
        check("mp_done_busy", 32'(bus.busy), 32'd0);
        check("mp_cnt", 32'(bus.mispred_cnt), 32'd1);

        // Mispredict under a three-cycle stall
        applyStimulus(0, 1, 32'h80, 0, 32'h0, 32'h10C, 1);
        check("st_pc_en_t0", 32'(bus.pc_en), 32'd0);
        applyStimulus(0, 1, 32'h999, 0, 32'h0, 32'h10C, 1);
        check("st_pc_en_t1", 32'(bus.pc_en), 32'd0);
        check("st_busy_t1", 32'(bus.busy), 32'd1);
        applyStimulus(0, 0, 32'h0, 0, 32'h0, 32'h10C, 1);
        check("st_pc_en_t2", 32'(bus.pc_en), 32'd0);
        applyStimulus(0, 0, 32'h0, 0, 32'h0, 32'h10C, 0);
        check("st_npc_t3", bus.npc, 32'h80);
        check("st_flush_t3", 32'(bus.flush_id_ex), 32'd1);
        applyStimulus(0, 0, 32'h0, 0, 32'h0, 32'h84, 0);
        applyStimulus(0, 0, 32'h0, 0, 32'h0, 32'h88, 0);
        check("st_cnt", 32'(bus.mispred_cnt), 32'd2);

        // Predicted taken, then simultaneous mispredict wins
        applyStimulus(0, 0, 32'h0, 1, 32'h40, 32'h8C, 0);
        check("pt_npc", bus.npc, 32'h40);
        check("pt_flush_id_ex", 32'(bus.flush_id_ex), 32'd0);
        check("pt_busy", 32'(bus.busy), 32'd0);
        applyStimulus(0, 1, 32'h10, 1, 32'h40, 32'h44, 0);
        check("both_npc", bus.npc, 32'h10);
        applyStimulus(0, 0, 32'h0, 0, 32'h0, 32'h14, 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(63) == 0), ($urandom_range(5) == 0),
                          $urandom & 32'hFFFF_FFFC, ($urandom_range(3) == 0),
                          $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC,
                          ($urandom_range(2) == 0));
        end

        // Reset in the middle of the squash window
        applyStimulus(1, 0, 32'h0, 0, 32'h0, 32'h0, 0);
        applyStimulus(0, 0, 32'h0, 0, 32'h0, 32'h4, 0);
        applyStimulus(0, 1, 32'h300, 0, 32'h0, 32'h8, 0);
        applyStimulus(1, 0, 32'h0, 0, 32'h0, 32'h304, 0);
        check("rsq_npc", bus.npc, 32'h0);
        check("rsq_busy", 32'(bus.busy), 32'd0);
        check("rsq_flush_id_ex", 32'(bus.flush_id_ex), 32'd1);
        applyStimulus(0, 0, 32'h0, 0, 32'h0, 32'h4, 0);
        check("rsq_after_busy", 32'(bus.busy), 32'd0);
        check("rsq_after_cnt", 32'(bus.mispred_cnt), 32'd0);
    endtask

    // FlushDepth=1 instance accepts one mispredict per cycle and stays IDLE.
    task automatic sat_flow();
        int exp_cnt;
        rst2 = 1'b1;
        bus2.mispred = 0; bus2.corr_pc = 32'h0; bus2.pred_taken = 0;
        bus2.pred_addr = 32'h0; bus2.seq_pc = 32'h0; bus2.stall = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst2 = 1'b0;
        bus2.mispred = 1; bus2.corr_pc = 32'h300; bus2.pred_taken = 1;
        bus2.pred_addr = 32'h500; bus2.seq_pc = 32'h600;
        for (int i = 1; i <= 65540; i++) begin
            @(posedge clk);
            #1;
            if (i == 1 || i == 2 || i == 1000 || (i >= 65533)) begin
                exp_cnt = (i > 65535) ? 65535 : i;
                check("sat_cnt", 32'(bus2.mispred_cnt), 32'(exp_cnt));
                check("sat_npc", bus2.npc, 32'h300);
                check("sat_flush_id_ex", 32'(bus2.flush_id_ex), 32'd1);
                check("sat_busy", 32'(bus2.busy), 32'd0);
            end
        end
    endtask

    task automatic checkOutput();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        m_pending = 0; m_pend_val = '0; m_squash_left = 0; m_cnt = 0;
        cur_rst = 1; cur_m = 0; cur_cp = '0; cur_pt = 0; cur_pa = '0; cur_sp = '0; cur_st = 0;
        rst = 1'b1;
        bus.mispred = 0; bus.corr_pc = '0; bus.pred_taken = 0;
        bus.pred_addr = '0; bus.seq_pc = '0; bus.stall = 0;
        $display("[TB] start");
        fork
            main_flow();
            sat_flow();
        join
        checkOutput();
        $finish;
    end

endmodule
